// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD read/write blocks:
// FSM state encoding, status-byte field positions and default bus timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EHIGH,
    ST_ELOW,
    ST_DONE
  } rd_state_e;

  localparam int BF_BIT = 7;
  localparam int ADDR_W = 7;

  // Cycle counts at 50 MHz, shared with the writer.
  localparam int LCD_T_AS      = 2;
  localparam int LCD_T_EH      = 12;
  localparam int LCD_T_EL      = 13;
  localparam int LCD_MAX_POLLS = 4096;

  localparam int TMR_W  = 16;
  localparam int POLL_W = 16;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times each bus phase; value sits at zero once
// a phase has run out, so expire stays high until the next load.
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic [TMR_W-1:0] value,
  output logic             expire
);

  logic [TMR_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign expire = (value_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-cycle engine: single status/data reads, or busy-flag polling
// with a retry limit. Pin outputs are registered from the next state.
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int T_AS      = LCD_T_AS,
  parameter int T_EH      = LCD_T_EH,
  parameter int T_EL      = LCD_T_EL,
  parameter int MAX_POLLS = LCD_MAX_POLLS
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rs,
  input  logic              req_poll,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_bf,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_timeout,
  output logic              bus_req,
  output logic              lcd_e,
  output logic              lcd_rw,
  output logic              lcd_rs,
  input  logic [7:0]        lcd_data_i
);

  localparam logic [TMR_W-1:0]  AS_LD    = TMR_W'(T_AS - 1);
  localparam logic [TMR_W-1:0]  EH_LD    = TMR_W'(T_EH - 1);
  localparam logic [TMR_W-1:0]  EL_LD    = TMR_W'(T_EL - 1);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(MAX_POLLS - 1);

  rd_state_e         state_q, state_d;
  logic              rs_q, rs_d;
  logic              poll_q, poll_d;
  logic [POLL_W-1:0] cnt_q, cnt_d;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_expire;
  logic              capture;

  logic [7:0]        rsp_data_q;
  logic              rsp_valid_q, rsp_bf_q, rsp_timeout_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic              lcd_e_q, lcd_rw_q, lcd_rs_q, bus_req_q;

  lcd_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  assign req_ready = (state_q == ST_IDLE) && !rst;
  // The byte is sampled on the same edge that takes E low.
  assign capture   = (state_q == ST_EHIGH) && (tmr_value == '0);

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    poll_d   = poll_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = ST_SETUP;
          rs_d     = req_rs;
          poll_d   = req_poll && !req_rs;
          cnt_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = AS_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_expire) begin
          state_d  = ST_EHIGH;
          tmr_load = 1'b1;
          tmr_val  = EH_LD;
        end
      end
      ST_EHIGH: begin
        if (capture) begin
          state_d  = ST_ELOW;
          tmr_load = 1'b1;
          tmr_val  = EL_LD;
        end
      end
      ST_ELOW: begin
        if (tmr_expire) begin
          // Re-polling skips SETUP: RS/RW have been held stable all along.
          if (poll_q && rsp_data_q[BF_BIT] && (cnt_q < POLL_LIM)) begin
            state_d  = ST_EHIGH;
            cnt_d    = cnt_q + 1'b1;
            tmr_load = 1'b1;
            tmr_val  = EH_LD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rs_q          <= 1'b0;
      poll_q        <= 1'b0;
      cnt_q         <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_bf_q      <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_timeout_q <= 1'b0;
      lcd_e_q       <= 1'b0;
      lcd_rw_q      <= 1'b0;
      lcd_rs_q      <= 1'b0;
      bus_req_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      poll_q      <= poll_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_d == ST_DONE);
      lcd_e_q     <= (state_d == ST_EHIGH);
      lcd_rw_q    <= (state_d != ST_IDLE);
      bus_req_q   <= (state_d != ST_IDLE);
      lcd_rs_q    <= (state_d != ST_IDLE) && rs_d;
      if (capture) begin
        rsp_data_q <= lcd_data_i;
      end
      if (state_d == ST_DONE) begin
        rsp_bf_q      <= !rs_q && rsp_data_q[BF_BIT];
        rsp_addr_q    <= rs_q ? '0 : rsp_data_q[ADDR_W-1:0];
        rsp_timeout_q <= poll_q && rsp_data_q[BF_BIT];
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_bf      = rsp_bf_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign lcd_e       = lcd_e_q;
  assign lcd_rw      = lcd_rw_q;
  assign lcd_rs      = lcd_rs_q;
  assign bus_req     = bus_req_q;

endmodule
